// File: rtl/digit_serial_sub_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master drives a request plus operands; the slave returns status and the registered result.
interface digit_serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             overflow;

  modport master (
    output start, A, B, Bin,
    input  ready, done, D, Bout, overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, done, D, Bout, overflow
  );
endinterface

// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: D = A - B - Bin, one DIGIT-bit slice per clock, LSB slice first.
// A single borrow flop links slices; results update only on entry to DONE.
module digit_serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  digit_serial_sub_if.slave  bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               ready_w;
  logic               done_w;
  logic               load_w;
  logic               last_slice_w;
  logic [DIGIT:0]     slice_w;
  logic [WIDTH+DIGIT-1:0] res_cat_w;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_slice_w) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on state only, so ready never combinationally follows start
  always_comb begin
    ready_w = (state_q == S_IDLE) || (state_q == S_DONE);
    done_w  = (state_q == S_DONE);
  end

  assign load_w       = ready_w && bus.start;
  assign last_slice_w = (cnt_q == CNT_W'(N - 1));
  assign slice_w      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, borrow_q};
  // New slice enters at the top; after N slices the first one sits at the bottom
  assign res_cat_w    = {slice_w[DIGIT-1:0], res_q};

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    if (load_w) begin
      a_d      = bus.A;
      b_d      = bus.B;
      borrow_d = bus.Bin;
      cnt_d    = '0;
      a_msb_d  = bus.A[WIDTH-1];
      b_msb_d  = bus.B[WIDTH-1];
    end else if (state_q == S_RUN) begin
      a_d      = a_q >> DIGIT;
      b_d      = b_q >> DIGIT;
      res_d    = res_cat_w[WIDTH+DIGIT-1:DIGIT];
      borrow_d = slice_w[DIGIT];
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_slice_w) begin
        d_d    = res_d;
        bout_d = slice_w[DIGIT];
        ovf_d  = (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
      end
    end
  end

  assign bus.ready    = ready_w;
  assign bus.done     = done_w;
  assign bus.D        = d_q;
  assign bus.Bout     = bout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_sub.sv
// Directed bench for digit_serial_sub at WIDTH=16, DIGIT=4, plus a short random sweep
// against an arithmetic reference of A - B - Bin.
module tb_digit_serial_sub;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  digit_serial_sub_if #(.WIDTH(16)) bus ();

  digit_serial_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start, waits for done, checks latency, held result and final outputs.
  // Returns in the done cycle.
  task automatic run_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] exp_d,
                         input logic exp_bout, input logic exp_ovf);
    int         lat;
    logic       held_ok;
    logic [15:0] prev_d;
    prev_d    = bus.D;
    held_ok   = 1'b1;
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    step();
    bus.start = 1'b0;
    bus.A     = 16'hDEAD;
    bus.B     = 16'hBEEF;
    bus.Bin   = 1'b1;
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (bus.D !== prev_d || bus.ready !== 1'b0) held_ok = 1'b0;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_hold"}, 32'(held_ok), 32'd1);
    chk({tag, "_D"}, 32'(bus.D), 32'(exp_d));
    chk({tag, "_Bout"}, 32'(bus.Bout), 32'(exp_bout));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    $display("op %s: A=%04h B=%04h Bin=%0d -> D=%04h Bout=%0d ovf=%0d lat=%0d",
             tag, a, b, bin, bus.D, bus.Bout, bus.overflow, lat);
  endtask

  initial begin
    int          done_cnt;
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] full;
    logic [15:0] md;
    logic        mo;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_Bout", 32'(bus.Bout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Directed vectors
    run_chk("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    step();
    chk("basic_done_pulse", 32'(bus.done), 32'd0);
    chk("basic_D_idle_hold", 32'(bus.D), 32'h0002);
    run_chk("ripple", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    step();
    run_chk("bin_only", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step();
    run_chk("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    step();
    run_chk("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    step();

    // Back-to-back: second start issued in the DONE cycle of the first
    run_chk("b2b_first", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_chk("b2b_second", 16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, 1'b0);
    step();

    // Start pulsed during RUN must be ignored
    bus.start = 1'b1;
    bus.A     = 16'hABCD;
    bus.B     = 16'h0BCD;
    bus.Bin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0001;
    bus.Bin   = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        done_cnt++;
        chk("runstart_D", 32'(bus.D), 32'hA000);
        chk("runstart_Bout", 32'(bus.Bout), 32'd0);
        chk("runstart_ovf", 32'(bus.overflow), 32'd0);
      end
      step();
    end
    chk("runstart_done_count", 32'(done_cnt), 32'd1);
    $display("op runstart: done pulses=%0d D=%04h", done_cnt, bus.D);

    // Reset in the middle of RUN
    bus.start = 1'b1;
    bus.A     = 16'h5555;
    bus.B     = 16'h1111;
    bus.Bin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_D", 32'(bus.D), 32'd0);
    chk("midrst_Bout", 32'(bus.Bout), 32'd0);
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) done_cnt++;
      step();
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    $display("op midrst: ready=%0d D=%04h", bus.ready, bus.D);
    run_chk("after_rst", 16'h00FF, 16'h000F, 1'b1, 16'h00EF, 1'b0, 1'b0);
    step();

    // Random sweep against the arithmetic reference
    for (int i = 0; i < 200; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      md   = full[15:0];
      mo   = (ra[15] != rb[15]) && (md[15] != ra[15]);
      run_chk($sformatf("rnd%0d", i), ra, rb, rbin, md, full[16], mo);
      if (i % 3 == 0) step();
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
